mem_port_arbiter: RTL and testbench

- Shares one backing memory port between two requesters: the fetch stage (port 0, read-only) and the load/store stage (port 1, read/write).
- Arbitration is round-robin, with a grant lock that holds each request stable until the memory accepts it.
- Each accepted request's source port is recorded in an in-order tag FIFO, so every memory response is routed back to the requester that issued it.
- It sits between the CPU pipeline stages and the cache/memory model, replacing the separate imem/dmem connections when a single-ported memory is used.

---
 rtl/mem_port_arbiter_pkg.sv | 12 +
 rtl/mem_port_arbiter_tag_fifo.sv | 71 +++++++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef logic [0:0] port_id_t;

  localparam port_id_t PORT_FETCH = 1'b0;
  localparam port_id_t PORT_DATA  = 1'b1;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// In-order FIFO of requester port ids, one entry per request in flight.
module tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  port_id_t        push_id,
  input  logic            pop,
  output port_id_t        head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  port_id_t            mem_q [Depth];
  port_id_t            mem_d [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (port 0) and
// load/store (port 1), routing in-order responses back via a tag FIFO.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [ADDR_W-1:0]            req0_addr,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic [ADDR_W-1:0]            req1_addr,
  input  logic                         req1_op,
  input  logic [DATA_W-1:0]            req1_wdata,
  output logic                         rsp0_valid,
  output logic                         rsp1_valid,
  output logic [DATA_W-1:0]            rsp0_data,
  output logic [DATA_W-1:0]            rsp1_data,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic                         mem_req_op,
  output logic [DATA_W-1:0]            mem_req_wdata,
  input  logic                         mem_rsp_valid,
  input  logic [DATA_W-1:0]            mem_rsp_data,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
  output logic                         err_stray_rsp
);

  localparam int unsigned CntW = $clog2(MAX_OUT + 1);

  port_id_t        last_q, last_d;
  port_id_t        lock_port_q, lock_port_d;
  logic            lock_v_q, lock_v_d;
  logic            err_q, err_d;

  port_id_t        gnt_port;
  logic            gnt_req;
  logic            accept;
  logic            pop;
  port_id_t        fifo_head;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

  // A stalled request keeps its grant so the requester sees stable handshake.
  always_comb begin
    if (lock_v_q) begin
      gnt_port = lock_port_q;
    end else if (req0_valid && req1_valid) begin
      gnt_port = ~last_q;
    end else if (req1_valid) begin
      gnt_port = PORT_DATA;
    end else begin
      gnt_port = PORT_FETCH;
    end
  end

  assign gnt_req       = (gnt_port == PORT_DATA) ? req1_valid : req0_valid;
  assign mem_req_valid = gnt_req && !fifo_full && !reset;
  assign accept        = mem_req_valid && mem_req_ready;

  assign req0_ready = accept && (gnt_port == PORT_FETCH);
  assign req1_ready = accept && (gnt_port == PORT_DATA);

  always_comb begin
    if (gnt_port == PORT_DATA) begin
      mem_req_addr  = req1_addr;
      mem_req_op    = req1_op;
      mem_req_wdata = req1_wdata;
    end else begin
      mem_req_addr  = req0_addr;
      mem_req_op    = MEM_READ;
      mem_req_wdata = '0;
    end
  end

  assign pop        = mem_rsp_valid && !fifo_empty && !reset;
  assign rsp0_valid = pop && (fifo_head == PORT_FETCH);
  assign rsp1_valid = pop && (fifo_head == PORT_DATA);
  assign rsp0_data  = mem_rsp_data;
  assign rsp1_data  = mem_rsp_data;

  assign outstanding   = reset ? '0 : fifo_count;
  assign err_stray_rsp = err_q && !reset;

  always_comb begin
    last_d      = accept ? gnt_port : last_q;
    err_d       = err_q | (mem_rsp_valid && fifo_empty);
    lock_v_d    = lock_v_q;
    lock_port_d = lock_port_q;
    if (accept) begin
      lock_v_d = 1'b0;
    end else if (mem_req_valid) begin
      lock_v_d    = 1'b1;
      lock_port_d = gnt_port;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q      <= PORT_DATA;
      lock_v_q    <= 1'b0;
      lock_port_q <= PORT_FETCH;
      err_q       <= 1'b0;
    end else begin
      last_q      <= last_d;
      lock_v_q    <= lock_v_d;
      lock_port_q <= lock_port_d;
      err_q       <= err_d;
    end
  end

  tag_fifo #(
    .Depth (MAX_OUT)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_id (gnt_port),
    .pop     (pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter; one vector per clock cycle.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_addr;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_addr;
  logic        req1_op;
  logic [31:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_op;
  logic [31:0] mem_req_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [2:0]  outstanding;
  logic        err_stray_rsp;

  mem_port_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_OUT (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_addr     (req0_addr),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_addr     (req1_addr),
    .req1_op       (req1_op),
    .req1_wdata    (req1_wdata),
    .rsp0_valid    (rsp0_valid),
    .rsp1_valid    (rsp1_valid),
    .rsp0_data     (rsp0_data),
    .rsp1_data     (rsp1_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_op    (mem_req_op),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .outstanding   (outstanding),
    .err_stray_rsp (err_stray_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        r0v;
    logic [31:0] r0a;
    logic        r1v;
    logic [31:0] r1a;
    logic        r1op;
    logic [31:0] r1wd;
    logic        mrdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        e_r0rdy;
    logic        e_r1rdy;
    logic        e_mv;
    logic [31:0] e_maddr;
    logic        e_mop;
    logic [31:0] e_mwd;
    logic        e_rsp0v;
    logic        e_rsp1v;
    logic [2:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  task automatic add(input string name, input logic [31:0] rst, r0v, r0a, r1v, r1a, r1op, r1wd,
                     input logic [31:0] mrdy, rspv, rspd, e_r0rdy, e_r1rdy, e_mv, e_maddr,
                     input logic [31:0] e_mop, e_mwd, e_rsp0v, e_rsp1v, e_out, e_err);
    vec_t v;
    v.name = name;      v.rst = rst[0];       v.r0v = r0v[0];     v.r0a = r0a;
    v.r1v = r1v[0];     v.r1a = r1a;          v.r1op = r1op[0];   v.r1wd = r1wd;
    v.mrdy = mrdy[0];   v.rspv = rspv[0];     v.rspd = rspd;
    v.e_r0rdy = e_r0rdy[0]; v.e_r1rdy = e_r1rdy[0]; v.e_mv = e_mv[0]; v.e_maddr = e_maddr;
    v.e_mop = e_mop[0]; v.e_mwd = e_mwd;      v.e_rsp0v = e_rsp0v[0]; v.e_rsp1v = e_rsp1v[0];
    v.e_out = e_out[2:0]; v.e_err = e_err[0];
    vecs.push_back(v);
  endtask

  task automatic check_vec(input vec_t v);
    logic ok;
    ok = (req0_ready === v.e_r0rdy) && (req1_ready === v.e_r1rdy) &&
         (mem_req_valid === v.e_mv) && (rsp0_valid === v.e_rsp0v) &&
         (rsp1_valid === v.e_rsp1v) && (outstanding === v.e_out) &&
         (err_stray_rsp === v.e_err);
    // Request fields are only meaningful while a request is presented.
    if (v.e_mv) begin
      ok &= (mem_req_addr === v.e_maddr) && (mem_req_op === v.e_mop) &&
            (mem_req_wdata === v.e_mwd);
    end
    if (v.rspv) ok &= (rsp0_data === v.rspd) && (rsp1_data === v.rspd);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got rdy=%b%b mv=%b addr=%h op=%b wd=%h rspv=%b%b d=%h/%h out=%0d err=%b; want rdy=%b%b mv=%b addr=%h op=%b wd=%h rspv=%b%b d=%h out=%0d err=%b",
               v.name, req0_ready, req1_ready, mem_req_valid, mem_req_addr, mem_req_op,
               mem_req_wdata, rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, outstanding,
               err_stray_rsp, v.e_r0rdy, v.e_r1rdy, v.e_mv, v.e_maddr, v.e_mop, v.e_mwd,
               v.e_rsp0v, v.e_rsp1v, v.rspd, v.e_out, v.e_err);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset = v.rst;          req0_valid = v.r0v;   req0_addr = v.r0a;
    req1_valid = v.r1v;     req1_addr = v.r1a;    req1_op = v.r1op;   req1_wdata = v.r1wd;
    mem_req_ready = v.mrdy; mem_rsp_valid = v.rspv; mem_rsp_data = v.rspd;
    #1;
    check_vec(v);
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;  req0_valid = 1'b0; req0_addr = '0; req1_valid = 1'b0; req1_addr = '0;
    req1_op = 1'b0; req1_wdata = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;

    //  name           rst r0v r0a    r1v r1a   op wd    rdy rv rd           er0 er1 emv eaddr eop ewd  ers0 ers1 eout eerr
    add("rst",          1, 1, 'h100, 0, 0,     0, 0,    1, 1, 'h5,         0, 0, 0, 0,     0, 0,    0, 0, 0, 0);
    add("f1_req",       0, 1, 'h100, 0, 0,     0, 0,    1, 0, 0,           1, 0, 1, 'h100, 0, 0,    0, 0, 0, 0);
    add("f1_wait",      0, 0, 0,     0, 0,     0, 0,    1, 0, 0,           0, 0, 0, 0,     0, 0,    0, 0, 1, 0);
    add("f1_rsp",       0, 0, 0,     0, 0,     0, 0,    1, 1, 'hDEADBEEF,  0, 0, 0, 0,     0, 0,    1, 0, 1, 0);
    add("f1_done",      0, 0, 0,     0, 0,     0, 0,    1, 0, 0,           0, 0, 0, 0,     0, 0,    0, 0, 0, 0);
    add("rst2",         1, 0, 0,     0, 0,     0, 0,    0, 0, 0,           0, 0, 0, 0,     0, 0,    0, 0, 0, 0);
    add("rr0",          0, 1, 'h200, 1, 'h300, 1, 'h77, 1, 0, 0,           1, 0, 1, 'h200, 0, 0,    0, 0, 0, 0);
    add("rr1",          0, 1, 'h200, 1, 'h300, 1, 'h77, 1, 1, 'h11,        0, 1, 1, 'h300, 1, 'h77, 1, 0, 1, 0);
    add("rr2",          0, 1, 'h200, 1, 'h300, 1, 'h77, 1, 1, 'h22,        1, 0, 1, 'h200, 0, 0,    0, 1, 1, 0);
    add("rr3",          0, 1, 'h200, 1, 'h300, 1, 'h77, 1, 1, 'h33,        0, 1, 1, 'h300, 1, 'h77, 1, 0, 1, 0);
    add("rr_drain",     0, 0, 0,     0, 0,     0, 0,    1, 1, 'h44,        0, 0, 0, 0,     0, 0,    0, 1, 1, 0);
    add("full_g0",      0, 1, 'h400, 0, 0,     0, 0,    1, 0, 0,           1, 0, 1, 'h400, 0, 0,    0, 0, 0, 0);
    add("full_g1",      0, 1, 'h400, 0, 0,     0, 0,    1, 0, 0,           1, 0, 1, 'h400, 0, 0,    0, 0, 1, 0);
    add("full_g2",      0, 1, 'h400, 0, 0,     0, 0,    1, 0, 0,           1, 0, 1, 'h400, 0, 0,    0, 0, 2, 0);
    add("full_g3",      0, 1, 'h400, 0, 0,     0, 0,    1, 0, 0,           1, 0, 1, 'h400, 0, 0,    0, 0, 3, 0);
    add("full_blk",     0, 1, 'h400, 1, 'h500, 0, 0,    1, 0, 0,           0, 0, 0, 0,     0, 0,    0, 0, 4, 0);
    add("full_pop",     0, 1, 'h400, 1, 'h500, 0, 0,    1, 1, 'h99,        0, 0, 0, 0,     0, 0,    1, 0, 4, 0);
    add("full_resume",  0, 1, 'h400, 1, 'h500, 0, 0,    1, 0, 0,           0, 1, 1, 'h500, 0, 0,    0, 0, 3, 0);
    add("full_pop2",    0, 0, 0,     0, 0,     0, 0,    1, 1, 'h1,         0, 0, 0, 0,     0, 0,    1, 0, 4, 0);
    add("rst3",         1, 0, 0,     0, 0,     0, 0,    0, 0, 0,           0, 0, 0, 0,     0, 0,    0, 0, 0, 0);
    add("lk_stall",     0, 0, 0,     1, 'h40,  1, 'h55, 0, 0, 0,           0, 0, 1, 'h40,  1, 'h55, 0, 0, 0, 0);
    add("lk_hold",      0, 1, 'h44,  1, 'h40,  1, 'h55, 0, 0, 0,           0, 0, 1, 'h40,  1, 'h55, 0, 0, 0, 0);
    add("lk_acc",       0, 1, 'h44,  1, 'h40,  1, 'h55, 1, 0, 0,           0, 1, 1, 'h40,  1, 'h55, 0, 0, 0, 0);
    add("lk_next",      0, 1, 'h44,  0, 0,     0, 0,    1, 0, 0,           1, 0, 1, 'h44,  0, 0,    0, 0, 1, 0);
    add("lk_rsp1",      0, 0, 0,     0, 0,     0, 0,    1, 1, 'hA1,        0, 0, 0, 0,     0, 0,    0, 1, 2, 0);
    add("lk_rsp0",      0, 0, 0,     0, 0,     0, 0,    1, 1, 'hA2,        0, 0, 0, 0,     0, 0,    1, 0, 1, 0);
    add("ord_r1",       0, 0, 0,     1, 'h20,  0, 0,    1, 0, 0,           0, 1, 1, 'h20,  0, 0,    0, 0, 0, 0);
    add("ord_r0",       0, 1, 'h24,  0, 0,     0, 0,    1, 0, 0,           1, 0, 1, 'h24,  0, 0,    0, 0, 1, 0);
    add("ord_aa",       0, 0, 0,     0, 0,     0, 0,    1, 1, 'hAA,        0, 0, 0, 0,     0, 0,    0, 1, 2, 0);
    add("ord_bb",       0, 0, 0,     0, 0,     0, 0,    1, 1, 'hBB,        0, 0, 0, 0,     0, 0,    1, 0, 1, 0);
    add("ord_idle",     0, 0, 0,     0, 0,     0, 0,    1, 0, 0,           0, 0, 0, 0,     0, 0,    0, 0, 0, 0);
    add("mf_r0",        0, 1, 'h60,  0, 0,     0, 0,    1, 0, 0,           1, 0, 1, 'h60,  0, 0,    0, 0, 0, 0);
    add("mf_r1",        0, 0, 0,     1, 'h64,  0, 0,    1, 0, 0,           0, 1, 1, 'h64,  0, 0,    0, 0, 1, 0);
    add("mf_two",       0, 0, 0,     0, 0,     0, 0,    1, 0, 0,           0, 0, 0, 0,     0, 0,    0, 0, 2, 0);
    add("mf_rst",       1, 0, 0,     0, 0,     0, 0,    1, 1, 'h5,         0, 0, 0, 0,     0, 0,    0, 0, 0, 0);
    add("mf_stray",     0, 0, 0,     0, 0,     0, 0,    1, 1, 'h6,         0, 0, 0, 0,     0, 0,    0, 0, 0, 0);
    add("mf_sticky",    0, 0, 0,     0, 0,     0, 0,    1, 0, 0,           0, 0, 0, 0,     0, 0,    0, 0, 0, 1);
    add("mf_after",     0, 1, 'h70,  0, 0,     0, 0,    1, 0, 0,           1, 0, 1, 'h70,  0, 0,    0, 0, 0, 1);

    foreach (vecs[i]) apply(vecs[i]);

    // Sustained contention from reset: grants alternate 0,1,0,1 with one in flight.
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0; req0_valid = 1'b1; req0_addr = 32'h800; req1_valid = 1'b1;
    req1_addr = 32'h900; req1_op = 1'b0; req1_wdata = '0; mem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_rsp_valid = (i > 0);
      mem_rsp_data  = 32'h1000 + i;
      #1;
      check1($sformatf("rr_seq_gnt%0d", i), {30'd0, req0_ready, req1_ready},
             (i % 2 == 1) ? 32'h1 : 32'h2);
      check1($sformatf("rr_seq_out%0d", i), {29'd0, outstanding}, (i > 0) ? 32'h1 : 32'h0);
      @(negedge clk);
    end

    // Drain: the last grant went to port 1, so its response must come back on rsp1.
    req0_valid = 1'b0; req1_valid = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE;
    begin
      int  budget;
      logic seen;
      budget = 0;
      seen   = 1'b0;
      while (!seen && budget < 5) begin
        #1;
        if (rsp0_valid || rsp1_valid) begin
          seen = 1'b1;
          check1("drain_rsp_port", {30'd0, rsp0_valid, rsp1_valid}, 32'h1);
        end
        @(negedge clk);
        budget++;
      end
      if (!seen) check1("drain_timeout", 32'h0, 32'h1);
      mem_rsp_valid = 1'b0;
      #1;
      check1("drain_out", {29'd0, outstanding}, 32'h0);
      check1("drain_err", {31'd0, err_stray_rsp}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
